// File: rtl/decoder_rll.sv
// Serial RLL(2,7) decoder: collects channel bits into 4/6/8-bit codewords,
// emits the decoded 2/3/4-bit group and flags bad codewords and (d,k) violations.
module decoder_rll #(
  parameter int MIN_ZERO_RUN = 2,
  parameter int MAX_ZERO_RUN = 7
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       code_i,
  input  logic       code_valid_i,
  output logic [3:0] data_o,
  output logic [2:0] data_len_o,
  output logic       data_valid_o,
  output logic       code_err_o,
  output logic       rl_err_o
);

  localparam logic [3:0] MinRun = 4'(MIN_ZERO_RUN);
  localparam logic [3:0] MaxRun = 4'(MAX_ZERO_RUN);

  logic [7:0] shift_q;
  logic [3:0] cnt_q;
  logic [3:0] zero_run_q;
  logic       seen_one_q;

  logic [7:0] shift_n;
  logic [3:0] cnt_n;
  logic       hit;
  logic       miss;
  logic [3:0] dec_data;
  logic [2:0] dec_len;
  logic       rl_short;
  logic       rl_long;

  assign shift_n = {shift_q[6:0], code_i};
  assign cnt_n   = cnt_q + 4'd1;

  // The code is prefix-free, so only the prefix completed by this bit is compared.
  always_comb begin
    hit      = 1'b0;
    miss     = 1'b0;
    dec_data = 4'd0;
    dec_len  = 3'd0;
    case (cnt_n)
      4'd4: begin
        case (shift_n[3:0])
          4'b1000: begin hit = 1'b1; dec_data = 4'b0011; dec_len = 3'd2; end
          4'b0100: begin hit = 1'b1; dec_data = 4'b0010; dec_len = 3'd2; end
          default: ;
        endcase
      end
      4'd6: begin
        case (shift_n[5:0])
          6'b100100: begin hit = 1'b1; dec_data = 4'b0010; dec_len = 3'd3; end
          6'b000100: begin hit = 1'b1; dec_data = 4'b0000; dec_len = 3'd3; end
          6'b001000: begin hit = 1'b1; dec_data = 4'b0011; dec_len = 3'd3; end
          default: ;
        endcase
      end
      4'd8: begin
        case (shift_n)
          8'b00100100: begin hit = 1'b1; dec_data = 4'b0010; dec_len = 3'd4; end
          8'b00001000: begin hit = 1'b1; dec_data = 4'b0011; dec_len = 3'd4; end
          default:     miss = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  // A long run flags only on the step into MAX+1 zeros, so one run yields one pulse.
  assign rl_short = seen_one_q && (zero_run_q < MinRun);
  assign rl_long  = (zero_run_q == MaxRun);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q      <= 8'd0;
      cnt_q        <= 4'd0;
      zero_run_q   <= 4'd0;
      seen_one_q   <= 1'b0;
      data_o       <= 4'd0;
      data_len_o   <= 3'd0;
      data_valid_o <= 1'b0;
      code_err_o   <= 1'b0;
      rl_err_o     <= 1'b0;
    end else begin
      data_valid_o <= 1'b0;
      code_err_o   <= 1'b0;
      rl_err_o     <= 1'b0;
      if (code_valid_i) begin
        if (hit) begin
          data_o       <= dec_data;
          data_len_o   <= dec_len;
          data_valid_o <= 1'b1;
          shift_q      <= 8'd0;
          cnt_q        <= 4'd0;
        end else if (miss) begin
          code_err_o <= 1'b1;
          shift_q    <= 8'd0;
          cnt_q      <= 4'd0;
        end else begin
          shift_q <= shift_n;
          cnt_q   <= cnt_n;
        end
        if (code_i) begin
          rl_err_o   <= rl_short;
          zero_run_q <= 4'd0;
          seen_one_q <= 1'b1;
        end else begin
          rl_err_o <= rl_long;
          if (zero_run_q != 4'd15) zero_run_q <= zero_run_q + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_decoder_rll.sv
// Directed bench for decoder_rll: table sweep, gaps, resync, run-length checks
// and reset behaviour, with hand-computed expectations.
module tb_decoder_rll;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       code_i;
  logic       code_valid_i;
  logic [3:0] data_o;
  logic [2:0] data_len_o;
  logic       data_valid_o;
  logic       code_err_o;
  logic       rl_err_o;

  int errors = 0;
  int checks = 0;
  int dv_cnt, ce_cnt, rl_cnt;

  decoder_rll #(.MIN_ZERO_RUN(2), .MAX_ZERO_RUN(7)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .code_i      (code_i),
    .code_valid_i(code_valid_i),
    .data_o      (data_o),
    .data_len_o  (data_len_o),
    .data_valid_o(data_valid_o),
    .code_err_o  (code_err_o),
    .rl_err_o    (rl_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_tally();
    dv_cnt = 0;
    ce_cnt = 0;
    rl_cnt = 0;
  endtask

  task automatic tally();
    if (data_valid_o === 1'b1) dv_cnt++;
    if (code_err_o === 1'b1) ce_cnt++;
    if (rl_err_o === 1'b1) rl_cnt++;
  endtask

  // Outputs are sampled 1 time unit after the edge that consumed the bit.
  task automatic send_bit(input logic b);
    code_i       = b;
    code_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    code_valid_i = 1'b0;
    code_i       = 1'b0;
    tally();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
      tally();
    end
  endtask

  task automatic send_word(input logic [7:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic apply_reset(input int n);
    rst_i        = 1'b1;
    code_valid_i = 1'b1;
    repeat (n) begin
      code_i = ~code_i;
      @(posedge clk_i);
      #1;
      check_output("reset_data",  8'(data_o),       8'd0);
      check_output("reset_len",   8'(data_len_o),   8'd0);
      check_output("reset_dv",    8'(data_valid_o), 8'd0);
      check_output("reset_ce",    8'(code_err_o),   8'd0);
      check_output("reset_rl",    8'(rl_err_o),     8'd0);
    end
    rst_i        = 1'b0;
    code_valid_i = 1'b0;
    code_i       = 1'b0;
  endtask

  logic [7:0] codes    [7] = '{8'b0000_1000, 8'b0000_0100, 8'b0010_0100, 8'b0000_0100,
                               8'b0000_1000, 8'b0010_0100, 8'b0000_1000};
  int         code_len [7] = '{4, 4, 6, 6, 6, 8, 8};
  logic [3:0] exp_data [7] = '{4'b0011, 4'b0010, 4'b0010, 4'b0000, 4'b0011, 4'b0010, 4'b0011};
  logic [2:0] exp_len  [7] = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4};

  initial begin
    code_i       = 1'b0;
    code_valid_i = 1'b0;
    rst_i        = 1'b1;

    // Reset held two cycles with bits toggling underneath.
    apply_reset(2);

    // Table sweep, back to back; no run-length violations in this stream.
    for (int i = 0; i < 7; i++) begin
      clear_tally();
      send_word(codes[i], code_len[i]);
      check_output($sformatf("sweep%0d_dv", i),   8'(data_valid_o), 8'd1);
      check_output($sformatf("sweep%0d_data", i), 8'(data_o),       8'(exp_data[i]));
      check_output($sformatf("sweep%0d_len", i),  8'(data_len_o),   8'(exp_len[i]));
      check_output($sformatf("sweep%0d_dvcnt", i), 8'(dv_cnt),      8'd1);
      check_output($sformatf("sweep%0d_ce", i),   8'(ce_cnt),       8'd0);
      check_output($sformatf("sweep%0d_rl", i),   8'(rl_cnt),       8'd0);
    end

    // Data and length hold between pulses.
    idle(1);
    check_output("hold_dv",   8'(data_valid_o), 8'd0);
    check_output("hold_data", 8'(data_o),       8'b0011);
    check_output("hold_len",  8'(data_len_o),   8'd4);

    // 0100 with three idle cycles between bits.
    clear_tally();
    send_bit(1'b0); idle(3);
    send_bit(1'b1); idle(3);
    send_bit(1'b0); idle(3);
    send_bit(1'b0);
    check_output("gap_dv",    8'(data_valid_o), 8'd1);
    check_output("gap_data",  8'(data_o),       8'b0010);
    check_output("gap_len",   8'(data_len_o),   8'd2);
    check_output("gap_dvcnt", 8'(dv_cnt),       8'd1);
    check_output("gap_rl",    8'(rl_cnt),       8'd0);

    // 11111111: code error after bit 8; bits 2..8 each violate d.
    clear_tally();
    send_word(8'hFF, 8);
    check_output("inv_ce",    8'(code_err_o),   8'd1);
    check_output("inv_dv",    8'(data_valid_o), 8'd0);
    check_output("inv_rl",    8'(rl_err_o),     8'd1);
    check_output("inv_cecnt", 8'(ce_cnt),       8'd1);
    check_output("inv_dvcnt", 8'(dv_cnt),       8'd0);
    check_output("inv_rlcnt", 8'(rl_cnt),       8'd7);

    // Resync: 1000 decodes; its leading 1 follows a 1 so d is violated once.
    clear_tally();
    send_word(8'b1000, 4);
    check_output("resync_dv",    8'(data_valid_o), 8'd1);
    check_output("resync_data",  8'(data_o),       8'b0011);
    check_output("resync_len",   8'(data_len_o),   8'd2);
    check_output("resync_cecnt", 8'(ce_cnt),       8'd0);
    check_output("resync_rlcnt", 8'(rl_cnt),       8'd1);

    // 1,0,1 after reset: first 1 exempt, second 1 violates d.
    apply_reset(1);
    clear_tally();
    send_bit(1'b1);
    check_output("d_first_rl",  8'(rl_err_o), 8'd0);
    send_bit(1'b0);
    check_output("d_zero_rl",   8'(rl_err_o), 8'd0);
    send_bit(1'b1);
    check_output("d_second_rl", 8'(rl_err_o), 8'd1);
    check_output("d_rlcnt",     8'(rl_cnt),   8'd1);

    // Nine zeros after reset: k flag on the 8th zero, also a code error at count 8.
    apply_reset(1);
    clear_tally();
    repeat (7) send_bit(1'b0);
    check_output("k_pre_rlcnt", 8'(rl_cnt),     8'd0);
    send_bit(1'b0);
    check_output("k_8_rl",      8'(rl_err_o),   8'd1);
    check_output("k_8_ce",      8'(code_err_o), 8'd1);
    send_bit(1'b0);
    check_output("k_9_rl",      8'(rl_err_o),   8'd0);
    idle(2);
    check_output("k_rlcnt",     8'(rl_cnt),     8'd1);
    check_output("k_cecnt",     8'(ce_cnt),     8'd1);

    // Partial 0010 discarded by reset; following 1000 decodes cleanly.
    apply_reset(1);
    clear_tally();
    send_word(8'b0010, 4);
    check_output("mid_pre_dvcnt", 8'(dv_cnt), 8'd0);
    check_output("mid_pre_cecnt", 8'(ce_cnt), 8'd0);
    apply_reset(1);
    clear_tally();
    send_word(8'b1000, 4);
    check_output("mid_dv",    8'(data_valid_o), 8'd1);
    check_output("mid_data",  8'(data_o),       8'b0011);
    check_output("mid_len",   8'(data_len_o),   8'd2);
    check_output("mid_cecnt", 8'(ce_cnt),       8'd0);
    check_output("mid_rlcnt", 8'(rl_cnt),       8'd0);
    check_output("mid_dvcnt", 8'(dv_cnt),       8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
